// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares RAM data port 2 between the core (C, fixed priority) and a DMA master
// (D, aging override and bounded locked bursts); read data returns one cycle after its grant.
module dmem_arbiter #(
   parameter int MAX_WAIT   = 4,
   parameter int BURST_MAX  = 8,
   localparam int WAIT_W    = $clog2(MAX_WAIT + 1),
   localparam int BURST_W   = $clog2(BURST_MAX + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   // core port
   input  logic               i_c_req,
   input  logic [31:0]        i_c_addr,
   input  logic [31:0]        i_c_w_data,
   input  logic [3:0]         i_c_we,
   output logic               o_c_gnt,
   output logic               o_c_r_valid,
   output logic [31:0]        o_c_r_data,
   // DMA port
   input  logic               i_d_req,
   input  logic               i_d_lock,
   input  logic [31:0]        i_d_addr,
   input  logic [31:0]        i_d_w_data,
   input  logic [3:0]         i_d_we,
   output logic               o_d_gnt,
   output logic               o_d_r_valid,
   output logic [31:0]        o_d_r_data,
   // RAM port 2
   output logic [31:0]        o_m_addr,
   output logic [31:0]        o_m_w_data,
   output logic [3:0]         o_m_we,
   input  logic [31:0]        i_m_r_data,
   // debug view of internal state (0 = ARB, 1 = D_BURST)
   output logic               o_dbg_state,
   output logic [WAIT_W-1:0]  o_dbg_d_wait,
   output logic [BURST_W-1:0] o_dbg_burst_cnt
);

   // Handshake: a requester raises req with addr/w_data/we stable and keeps them until gnt;
   // gnt is combinational and marks the cycle in which the transfer reaches the RAM edge.

   typedef enum logic {
      ST_ARB     = 1'b0,
      ST_D_BURST = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WAIT_W-1:0]    r_d_wait;
   logic [WAIT_W-1:0]    w_d_wait_nxt;
   logic [BURST_W-1:0]   r_burst_cnt;
   logic [BURST_W-1:0]   w_burst_nxt;
   logic [BURST_W-1:0]   w_burst_inc;
   logic                 w_burst_exit;
   logic                 r_rd_pend;
   logic                 r_rd_owner;
   logic                 w_c_gnt;
   logic                 w_d_gnt;
   logic                 w_rd_issue;

   assign w_burst_inc = r_burst_cnt + BURST_W'(1);

   // Grant selection
   always_comb begin
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!i_rst) begin
         if (r_state == ST_D_BURST) begin
            w_d_gnt = i_d_req;
         end else if (i_c_req && i_d_req) begin
            if (r_d_wait == WAIT_W'(MAX_WAIT)) w_d_gnt = 1'b1;
            else                               w_c_gnt = 1'b1;
         end else begin
            w_c_gnt = i_c_req;
            w_d_gnt = i_d_req;
         end
      end
   end

   // Burst exit fires on the grant that reaches BURST_MAX, so C gets the very next slot.
   always_comb begin
      w_state_nxt  = r_state;
      w_burst_nxt  = r_burst_cnt;
      w_burst_exit = 1'b0;
      case (r_state)
         ST_ARB: begin
            w_burst_nxt = '0;
            if (w_d_gnt && i_d_lock && (BURST_MAX > 1)) begin
               w_state_nxt = ST_D_BURST;
               w_burst_nxt = BURST_W'(1);
            end
         end
         ST_D_BURST: begin
            if (w_d_gnt) w_burst_nxt = w_burst_inc;
            if (!i_d_lock || !i_d_req || (w_burst_inc == BURST_W'(BURST_MAX))) begin
               w_burst_exit = 1'b1;
               w_state_nxt  = ST_ARB;
               w_burst_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_ARB;
            w_burst_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_d_wait_nxt = r_d_wait;
      if (w_d_gnt || !i_d_req || w_burst_exit) begin
         w_d_wait_nxt = '0;
      end else if (r_d_wait != WAIT_W'(MAX_WAIT)) begin
         w_d_wait_nxt = r_d_wait + WAIT_W'(1);
      end
   end

   assign w_rd_issue = (w_c_gnt && (i_c_we == 4'h0)) || (w_d_gnt && (i_d_we == 4'h0));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_ARB;
         r_d_wait    <= '0;
         r_burst_cnt <= '0;
         r_rd_pend   <= 1'b0;
         r_rd_owner  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_d_wait    <= w_d_wait_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_rd_pend   <= w_rd_issue;
         r_rd_owner  <= w_d_gnt;
      end
   end

   // With no grant the C fields still drive addr/data so the RAM sees a stable, harmless read.
   always_comb begin
      o_m_addr   = i_c_addr;
      o_m_w_data = i_c_w_data;
      o_m_we     = 4'h0;
      if (w_d_gnt) begin
         o_m_addr   = i_d_addr;
         o_m_w_data = i_d_w_data;
         o_m_we     = i_d_we;
      end else if (w_c_gnt) begin
         o_m_we     = i_c_we;
      end
   end

   assign o_c_gnt         = w_c_gnt;
   assign o_d_gnt         = w_d_gnt;
   assign o_c_r_valid     = r_rd_pend && !r_rd_owner && !i_rst;
   assign o_d_r_valid     = r_rd_pend &&  r_rd_owner && !i_rst;
   assign o_c_r_data      = i_m_r_data;
   assign o_d_r_data      = i_m_r_data;
   assign o_dbg_state     = r_state;
   assign o_dbg_d_wait    = r_d_wait;
   assign o_dbg_burst_cnt = r_burst_cnt;

endmodule
